// File: rtl/nrzi_unstuff_deser.sv
// NRZI receive decoder: strips stuffed bits, flags stuffing violations and
// packs payload LSB-first into words, flushing a partial word at end of packet.
module nrzi_unstuff_deser #(
  parameter int QUAL_W     = 9,
  parameter int STUFF_LEN  = 6,
  parameter int DATA_W     = 8,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic                          gclk,
  input  logic                          reset_l,
  input  logic                          start_rxd,
  input  logic                          rx_data_in,
  input  logic [QUAL_W-1:0]             qual_in,
  output logic                          rx_data_out,
  output logic                          rx_data_valid,
  output logic [QUAL_W-1:0]             qual_out,
  output logic                          stuff_err,
  output logic [DATA_W-1:0]             rx_word,
  output logic                          rx_word_valid,
  output logic                          rx_word_partial,
  output logic [$clog2(DATA_W+1)-1:0]   rx_word_bits,
  output logic [1:0]                    dbg_state
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int OW = $clog2(STUFF_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  // Handshake: rx_data_valid qualifies rx_data_out for one cycle; rx_word_valid
  // is a one-cycle strobe qualifying rx_word, rx_word_partial and rx_word_bits.
  // There is no backpressure: the consumer must take every strobe.

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last;
  logic [OW-1:0]       r_ones;
  logic [CW-1:0]       r_bit_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_data_out;
  logic                r_data_valid;
  logic [QUAL_W-1:0]   r_qual;
  logic                r_err;
  logic [DATA_W-1:0]   r_word;
  logic                r_word_valid;
  logic                r_word_partial;
  logic [CW-1:0]       r_word_bits;

  logic                w_dec;
  logic [IW-1:0]       w_idx;
  logic [DATA_W-1:0]   w_shift_ins;
  logic [OW-1:0]       w_ones_nxt;
  logic [CW-1:0]       w_bit_cnt_nxt;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                w_data_out;
  logic                w_data_valid;
  logic                w_err;
  logic [DATA_W-1:0]   w_word;
  logic                w_word_valid;
  logic                w_word_partial;
  logic [CW-1:0]       w_word_bits;

  always_comb begin
    w_dec          = (start_rxd && (rx_data_in != r_last)) ? 1'b0 : 1'b1;
    w_idx          = r_bit_cnt[IW-1:0];
    // A new word starts from zero so a later flush has its upper bits clear.
    w_shift_ins    = (r_bit_cnt == '0) ? '0 : r_shift;
    w_shift_ins[w_idx] = w_dec;

    w_state_nxt    = r_state;
    w_ones_nxt     = '0;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_data_out     = 1'b1;
    w_data_valid   = 1'b0;
    w_err          = 1'b0;
    w_word         = r_word;
    w_word_valid   = 1'b0;
    w_word_partial = 1'b0;
    w_word_bits    = r_word_bits;

    case (r_state)
      S_IDLE, S_RECV: begin
        if (start_rxd) begin
          w_state_nxt = S_RECV;
          if (r_ones < OW'(STUFF_LEN)) begin
            w_data_valid = 1'b1;
            w_data_out   = w_dec;
            w_ones_nxt   = w_dec ? (r_ones + OW'(1)) : '0;
            w_shift_nxt  = w_shift_ins;
            if (r_bit_cnt == CW'(DATA_W - 1)) begin
              w_word         = w_shift_ins;
              w_word_valid   = 1'b1;
              w_word_bits    = CW'(DATA_W);
              w_bit_cnt_nxt  = '0;
            end else begin
              w_bit_cnt_nxt  = r_bit_cnt + CW'(1);
            end
          end else if (w_dec) begin
            w_state_nxt   = S_ERR;
            w_err         = 1'b1;
            w_bit_cnt_nxt = '0;
          end
        end else begin
          w_state_nxt   = S_IDLE;
          w_bit_cnt_nxt = '0;
          if ((r_state == S_RECV) && (r_bit_cnt != '0)) begin
            w_word         = r_shift;
            w_word_valid   = 1'b1;
            w_word_partial = 1'b1;
            w_word_bits    = r_bit_cnt;
          end
        end
      end
      S_ERR: begin
        w_bit_cnt_nxt = '0;
        if (start_rxd) begin
          w_err = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_bit_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      r_state        <= S_IDLE;
      r_last         <= IDLE_LEVEL;
      r_ones         <= '0;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_data_out     <= 1'b1;
      r_data_valid   <= 1'b0;
      r_qual         <= '0;
      r_err          <= 1'b0;
      r_word         <= '0;
      r_word_valid   <= 1'b0;
      r_word_partial <= 1'b0;
      r_word_bits    <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_last         <= rx_data_in;
      r_ones         <= w_ones_nxt;
      r_bit_cnt      <= w_bit_cnt_nxt;
      r_shift        <= w_shift_nxt;
      r_data_out     <= w_data_out;
      r_data_valid   <= w_data_valid;
      r_qual         <= qual_in;
      r_err          <= w_err;
      r_word         <= w_word;
      r_word_valid   <= w_word_valid;
      r_word_partial <= w_word_partial;
      r_word_bits    <= w_word_bits;
    end
  end

  assign rx_data_out     = r_data_out;
  assign rx_data_valid   = r_data_valid;
  assign qual_out        = r_qual;
  assign stuff_err       = r_err;
  assign rx_word         = r_word;
  assign rx_word_valid   = r_word_valid;
  assign rx_word_partial = r_word_partial;
  assign rx_word_bits    = r_word_bits;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_nrzi_unstuff_deser.sv
// Bench for nrzi_unstuff_deser: decode table, hand-written corner sequences and
// random packets against a queue-based reference model.
module tb_nrzi_unstuff_deser;

  localparam int QW = 9;
  localparam int SL = 6;
  localparam int DW = 8;
  localparam int BW = $clog2(DW + 1);

  logic          gclk = 1'b0;
  logic          reset_l = 1'b1;
  logic          start_rxd = 1'b0;
  logic          rx_data_in = 1'b1;
  logic [QW-1:0] qual_in = '0;
  logic          rx_data_out;
  logic          rx_data_valid;
  logic [QW-1:0] qual_out;
  logic          stuff_err;
  logic [DW-1:0] rx_word;
  logic          rx_word_valid;
  logic          rx_word_partial;
  logic [BW-1:0] rx_word_bits;
  logic [1:0]    dbg_state;

  nrzi_unstuff_deser #(.QUAL_W(QW), .STUFF_LEN(SL), .DATA_W(DW), .IDLE_LEVEL(1'b1)) dut (
    .gclk(gclk), .reset_l(reset_l), .start_rxd(start_rxd), .rx_data_in(rx_data_in),
    .qual_in(qual_in), .rx_data_out(rx_data_out), .rx_data_valid(rx_data_valid),
    .qual_out(qual_out), .stuff_err(stuff_err), .rx_word(rx_word),
    .rx_word_valid(rx_word_valid), .rx_word_partial(rx_word_partial),
    .rx_word_bits(rx_word_bits), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 gclk = ~gclk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: packet mode, line history, run of ones, pending payload bits
  int            m_mode;   // 0 idle, 1 receiving, 2 error
  bit            m_last;
  int            m_ones;
  bit            m_bits[$];
  bit            e_out, e_valid, e_err, e_wv, e_part;
  logic [DW-1:0] e_word;
  int            e_nbits;
  logic [QW-1:0] e_qual;
  logic [DW-1:0] exp_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_last = 1'b1; m_ones = 0; m_bits.delete();
    e_out = 1'b1; e_valid = 1'b0; e_err = 1'b0; e_wv = 1'b0; e_part = 1'b0;
    e_word = '0; e_nbits = 0; e_qual = '0;
    exp_q.delete();
  endtask

  task automatic pack_bits();
    e_word = '0;
    foreach (m_bits[i]) e_word[i] = m_bits[i];
    e_nbits = m_bits.size();
  endtask

  task automatic model_step(bit s, bit d, logic [QW-1:0] q);
    bit dec;
    dec = (s && (d != m_last)) ? 1'b0 : 1'b1;
    m_last = d;
    e_qual = q; e_out = 1'b1; e_valid = 1'b0; e_wv = 1'b0;
    if (!s) begin
      if (m_mode == 1 && m_bits.size() > 0) begin
        pack_bits(); e_wv = 1'b1; e_part = 1'b1;
      end
      m_bits.delete(); m_mode = 0; m_ones = 0;
    end else if (m_mode != 2) begin
      m_mode = 1;
      if (m_ones < SL) begin
        e_valid = 1'b1; e_out = dec;
        m_ones = dec ? m_ones + 1 : 0;
        m_bits.push_back(dec);
        if (m_bits.size() == DW) begin
          pack_bits(); e_wv = 1'b1; e_part = 1'b0;
          m_bits.delete();
        end
      end else if (!dec) begin
        m_ones = 0;
      end else begin
        m_mode = 2; m_ones = 0; m_bits.delete();
      end
    end
    e_err = (m_mode == 2);
    if (e_wv) exp_q.push_back(e_word);
  endtask

  task automatic compare_all();
    check("data_out", rx_data_out, e_out);
    check("data_valid", rx_data_valid, e_valid);
    check("stuff_err", stuff_err, e_err);
    check("qual_out", qual_out, e_qual);
    check("word_valid", rx_word_valid, e_wv);
    check("word_hold", rx_word, e_word);
    if (e_wv) begin
      check("word_partial", rx_word_partial, e_part);
      check("word_bits", rx_word_bits, e_nbits);
    end
    if (rx_word_valid) begin
      if (exp_q.size() == 0) check("sb_spurious_strobe", 1, 0);
      else check("sb_word", rx_word, exp_q.pop_front());
    end
  endtask

  // driver: one cycle of inputs, model update, compare away from the edge
  task automatic step(bit s, bit d, logic [QW-1:0] q);
    @(negedge gclk);
    start_rxd = s; rx_data_in = d; qual_in = q;
    @(posedge gclk);
    model_step(s, d, q);
    #1;
    compare_all();
  endtask

  typedef struct {
    bit            s;
    bit            d;
    bit            x_out;
    bit            x_valid;
    bit            x_wv;
    logic [DW-1:0] x_word;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit [7:0] line;
    bit [7:0] dec_exp;
    bit       lv;
    int       run, strobes, plen, keep_pct, gap;

    // reset
    model_reset();
    #2 reset_l = 1'b0;
    #1;
    check("rst_data_out", rx_data_out, 1);
    check("rst_data_valid", rx_data_valid, 0);
    check("rst_qual", qual_out, 0);
    check("rst_stuff_err", stuff_err, 0);
    check("rst_word", rx_word, 0);
    check("rst_word_valid", rx_word_valid, 0);
    check("rst_word_partial", rx_word_partial, 0);
    check("rst_word_bits", rx_word_bits, 0);
    repeat (2) @(negedge gclk);
    reset_l = 1'b1;
    repeat (3) step(1'b0, 1'b1, '0);

    // table: NRZI decode of one full word, line parked low beforehand
    line    = 8'b1101_0101;
    dec_exp = 8'b1000_0000;
    tbl[0] = '{s: 1'b0, d: 1'b0, x_out: 1'b1, x_valid: 1'b0, x_wv: 1'b0, x_word: '0};
    for (int i = 0; i < 8; i++)
      tbl[i+1] = '{s: 1'b1, d: line[i], x_out: dec_exp[i], x_valid: 1'b1,
                   x_wv: (i == 7), x_word: 8'h80};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].s, tbl[i].d, '0);
      check($sformatf("tbl_out[%0d]", i), rx_data_out, tbl[i].x_out);
      check($sformatf("tbl_valid[%0d]", i), rx_data_valid, tbl[i].x_valid);
      check($sformatf("tbl_wv[%0d]", i), rx_word_valid, tbl[i].x_wv);
      if (tbl[i].x_wv) check("tbl_word", rx_word, tbl[i].x_word);
    end
    step(1'b0, 1'b1, '0);
    check("tbl_no_flush", rx_word_valid, 0);

    // stuffed bit after six ones, then a real zero, then flush of 7 bits
    step(1'b0, 1'b1, '0);
    repeat (6) step(1'b1, 1'b1, '0);
    step(1'b1, 1'b0, '0);
    check("stuff_valid_low", rx_data_valid, 0);
    check("stuff_out_high", rx_data_out, 1);
    step(1'b1, 1'b1, '0);
    check("post_stuff_valid", rx_data_valid, 1);
    check("post_stuff_out", rx_data_out, 0);
    step(1'b0, 1'b1, '0);
    check("stuff_flush_valid", rx_word_valid, 1);
    check("stuff_flush_word", rx_word, 8'h3F);
    check("stuff_flush_bits", rx_word_bits, 7);
    check("stuff_flush_partial", rx_word_partial, 1);

    // seven decoded ones: violation held until start_rxd drops, no strobe
    step(1'b0, 1'b1, '0);
    repeat (7) step(1'b1, 1'b1, '0);
    check("viol_err", stuff_err, 1);
    check("viol_valid", rx_data_valid, 0);
    repeat (2) begin
      step(1'b1, 1'b1, '0);
      check("viol_hold_err", stuff_err, 1);
      check("viol_hold_valid", rx_data_valid, 0);
    end
    step(1'b0, 1'b1, '0);
    check("viol_clear", stuff_err, 0);
    check("viol_no_strobe", rx_word_valid, 0);

    // eleven payload bits: one full word then a 3-bit partial flush
    step(1'b0, 1'b1, '0);
    lv = 1'b1; run = 0; strobes = 0;
    for (int i = 0; i < 11; i++) begin
      if (run == 3 || $urandom_range(1, 0) == 1) begin lv = ~lv; run = 0; end
      else run++;
      step(1'b1, lv, '0);
      if (rx_word_valid) begin
        strobes++;
        check("w11_full_partial", rx_word_partial, 0);
        check("w11_full_bits", rx_word_bits, DW);
      end
    end
    check("w11_full_count", strobes, 1);
    step(1'b0, 1'b1, '0);
    check("w11_flush_valid", rx_word_valid, 1);
    check("w11_flush_bits", rx_word_bits, 3);
    check("w11_flush_partial", rx_word_partial, 1);
    check("w11_flush_upper", rx_word[7:3], 0);

    // qualifier delay
    step(1'b0, 1'b1, 9'h1A5);
    check("qual_1a5", qual_out, 9'h1A5);
    step(1'b0, 1'b1, '0);
    check("qual_back_0", qual_out, 0);

    // asynchronous reset mid-word
    step(1'b0, 1'b1, '0);
    lv = 1'b1;
    repeat (4) begin lv = ~lv; step(1'b1, lv, 9'h0F0); end
    #2 reset_l = 1'b0;
    #1;
    model_reset();
    check("midrst_out", rx_data_out, 1);
    check("midrst_valid", rx_data_valid, 0);
    check("midrst_wv", rx_word_valid, 0);
    check("midrst_word", rx_word, 0);
    check("midrst_qual", qual_out, 0);
    @(negedge gclk);
    reset_l = 1'b1;
    start_rxd = 1'b0;
    repeat (3) step(1'b0, 1'b1, '0);

    // random packets
    lv = 1'b1;
    for (int p = 0; p < 80; p++) begin
      plen = $urandom_range(60, 4);
      case ($urandom_range(2, 0))
        0: keep_pct = 30;
        1: keep_pct = 60;
        default: keep_pct = 85;
      endcase
      for (int i = 0; i < plen; i++) begin
        if ($urandom_range(99, 0) >= keep_pct) lv = ~lv;
        step(1'b1, lv, QW'($urandom));
      end
      gap = $urandom_range(3, 1);
      for (int i = 0; i < gap; i++) begin
        lv = $urandom_range(1, 0);
        step(1'b0, lv, QW'($urandom));
      end
    end
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
